// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   - tx_state_t      : transmitter FSM state encoding
//   - PARITY_*        : parity mode selectors for the PARITY parameter
//   - UART_BAUD_W     : default width of the clocks-per-bit setting
//   - tx_parity()     : parity of the low nbits of a data word
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BAUD_W = 24;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_BREAK  = 3'd5,
    TX_GUARD  = 3'd6
  } tx_state_t;

  // Parity over data[nbits-1:0] only; odd mode inverts the XOR reduction.
  function automatic logic tx_parity(input logic [7:0] data, input int nbits, input int mode);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) begin
        acc = acc ^ data[i];
      end else begin
        acc = acc;
      end
    end
    if (mode == PARITY_ODD) begin
      return ~acc;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/txuart_baudgen.sv
// -----------------------------------------------------------------------------
// txuart_baudgen
// Bit-time down-counter for the UART transmitter. A load strobe presets the
// counter to (bit time - 1); while running it counts down to zero and
// bit_done is high in the final cycle of the bit. It holds when not running.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   load       : preset counter to load_val (start of a new bit)
//   load_val   : bit time minus one
//   run        : a timed bit is in progress
//   bit_done   : last cycle of the current bit
// -----------------------------------------------------------------------------
module txuart_baudgen
  import uart_pkg::*;
#(
  parameter int BAUD_W = UART_BAUD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BAUD_W-1:0] load_val,
  input  logic              run,
  output logic              bit_done
);

  logic [BAUD_W-1:0] cnt;

  // Down-counter: preset on load, stops at zero so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {BAUD_W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (run && (cnt != {BAUD_W{1'b0}})) begin
      cnt <= cnt - {{(BAUD_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  assign bit_done = run & (cnt == {BAUD_W{1'b0}});

endmodule

// File: rtl/fifo_txuart.sv
// -----------------------------------------------------------------------------
// fifo_txuart
// Serial transmitter draining a byte FIFO read port. Emits frames of
// start, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
// New characters start only at character boundaries, gated by CTS and break.
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_setup         : clocks per bit (0 treated as 1), latched per character
//   i_fifo_empty_n  : FIFO holds data, i_fifo_data valid
//   i_fifo_data     : FIFO head word
//   o_fifo_rd       : one-cycle pop strobe
//   i_cts_n         : active-low clear-to-send
//   i_break         : hold the line low (break) when idle at a boundary
//   o_uart_tx       : serial line, idle high
//   o_busy          : character, break or guard interval in progress
// -----------------------------------------------------------------------------
module fifo_txuart
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PARITY_NONE,
  parameter int BAUD_W    = UART_BAUD_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BAUD_W-1:0] i_setup,
  input  logic              i_fifo_empty_n,
  input  logic [7:0]        i_fifo_data,
  output logic              o_fifo_rd,
  input  logic              i_cts_n,
  input  logic              i_break,
  output logic              o_uart_tx,
  output logic              o_busy
);

  localparam logic [2:0] S_IDLE   = TX_IDLE;
  localparam logic [2:0] S_START  = TX_START;
  localparam logic [2:0] S_DATA   = TX_DATA;
  localparam logic [2:0] S_PARITY = TX_PARITY;
  localparam logic [2:0] S_STOP   = TX_STOP;
  localparam logic [2:0] S_BREAK  = TX_BREAK;
  localparam logic [2:0] S_GUARD  = TX_GUARD;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

  logic [2:0]        state;
  logic [BAUD_W-1:0] eff_m1;
  logic [7:0]        shreg;
  logic              par;
  logic [2:0]        bit_cnt;
  logic              tx;
  logic              busy;

  logic [BAUD_W-1:0] setup_m1;
  logic              eligible;
  logic              char_end;
  logic              boundary;
  logic              launch;
  logic              baud_load;
  logic [BAUD_W-1:0] load_val;
  logic              baud_run;
  logic              bit_done;

  // Boundary detection, launch decision and baud counter control.
  always_comb begin
    setup_m1  = {BAUD_W{1'b0}};
    eligible  = 1'b0;
    char_end  = 1'b0;
    boundary  = 1'b0;
    launch    = 1'b0;
    baud_load = 1'b0;
    load_val  = eff_m1;
    baud_run  = 1'b0;

    // A zero setting behaves as a one-cycle bit.
    if (i_setup == {BAUD_W{1'b0}}) begin
      setup_m1 = {BAUD_W{1'b0}};
    end else begin
      setup_m1 = i_setup - {{(BAUD_W-1){1'b0}}, 1'b1};
    end

    eligible = i_fifo_empty_n & ~i_cts_n & ~i_break;

    if ((state == S_START) || (state == S_DATA) || (state == S_PARITY) ||
        (state == S_STOP) || (state == S_GUARD)) begin
      baud_run = 1'b1;
    end else begin
      baud_run = 1'b0;
    end

    // Final cycle of the last stop bit or of the guard interval.
    if (bit_done && (((state == S_STOP) && (bit_cnt == LAST_STOP)) || (state == S_GUARD))) begin
      char_end = 1'b1;
    end else begin
      char_end = 1'b0;
    end

    boundary = (state == S_IDLE) | char_end;
    launch   = boundary & eligible & ~i_rst;

    // Reload the counter whenever a new timed bit begins next cycle.
    if (launch) begin
      baud_load = 1'b1;
      load_val  = setup_m1;
    end else if ((state == S_BREAK) && !i_break) begin
      baud_load = 1'b1;
      load_val  = setup_m1;
    end else if (bit_done && !char_end) begin
      baud_load = 1'b1;
      load_val  = eff_m1;
    end else begin
      baud_load = 1'b0;
      load_val  = eff_m1;
    end
  end

  txuart_baudgen #(
    .BAUD_W(BAUD_W)
  ) u_baudgen (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (baud_load),
    .load_val (load_val),
    .run      (baud_run),
    .bit_done (bit_done)
  );

  // Transmit FSM, shift register and registered line/busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      eff_m1  <= {BAUD_W{1'b0}};
      shreg   <= 8'h00;
      par     <= 1'b0;
      bit_cnt <= 3'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else if (boundary) begin
      // Character boundary: start the next character, break, or go idle.
      if (launch) begin
        state   <= S_START;
        eff_m1  <= setup_m1;
        shreg   <= i_fifo_data & DATA_MASK;
        par     <= tx_parity(i_fifo_data, DATA_BITS, PARITY);
        bit_cnt <= 3'd0;
        tx      <= 1'b0;
        busy    <= 1'b1;
      end else if (i_break) begin
        state <= S_BREAK;
        tx    <= 1'b0;
        busy  <= 1'b1;
      end else begin
        state <= S_IDLE;
        tx    <= 1'b1;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= 3'd0;
              if (PARITY != PARITY_NONE) begin
                state <= S_PARITY;
                tx    <= par;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state   <= S_STOP;
            tx      <= 1'b1;
            bit_cnt <= 3'd0;
          end
        end
        S_STOP: begin
          // The last stop bit is handled as a boundary above.
          if (bit_done) begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_BREAK: begin
          if (!i_break) begin
            state <= S_GUARD;
            tx    <= 1'b1;
          end
        end
        S_GUARD: begin
          tx <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd = launch;
  assign o_uart_tx = tx;
  assign o_busy    = busy;

endmodule

// File: tb/tb_fifo_txuart.sv
// -----------------------------------------------------------------------------
// tb_fifo_txuart
// Three transmitter instances (8N1, 8E1, 7O2) fed from queue-based FIFOs.
// Expected line, pop and busy waveforms are built from frame rules and
// compared cycle by cycle with the logged DUT outputs.
// -----------------------------------------------------------------------------
module tb_fifo_txuart;

  localparam int BW   = 24;
  localparam int LOGN = 512;
  localparam int DB [3] = '{8, 8, 7};
  localparam int PA [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 1, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic          cts_n;
  logic          brk;
  logic [BW-1:0] setup;
  logic [2:0]    empty_n;
  logic [7:0]    fdata [0:2];
  logic [2:0]    rd;
  logic [2:0]    tx;
  logic [2:0]    busy;

  logic [7:0] fq [0:2][$];

  logic tx_log   [0:2][0:LOGN-1];
  logic rd_log   [0:2][0:LOGN-1];
  logic busy_log [0:2][0:LOGN-1];
  logic exp_tx   [0:2][0:LOGN-1];
  logic exp_rd   [0:2][0:LOGN-1];
  logic exp_busy [0:2][0:LOGN-1];

  int cyc;
  int checks;
  int errors;

  always #5 clk = ~clk;

  fifo_txuart #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .BAUD_W(BW)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_setup(setup), .i_fifo_empty_n(empty_n[0]),
    .i_fifo_data(fdata[0]), .o_fifo_rd(rd[0]), .i_cts_n(cts_n), .i_break(brk),
    .o_uart_tx(tx[0]), .o_busy(busy[0]));

  fifo_txuart #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .BAUD_W(BW)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_setup(setup), .i_fifo_empty_n(empty_n[1]),
    .i_fifo_data(fdata[1]), .o_fifo_rd(rd[1]), .i_cts_n(cts_n), .i_break(brk),
    .o_uart_tx(tx[1]), .o_busy(busy[1]));

  fifo_txuart #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(1), .BAUD_W(BW)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_setup(setup), .i_fifo_empty_n(empty_n[2]),
    .i_fifo_data(fdata[2]), .o_fifo_rd(rd[2]), .i_cts_n(cts_n), .i_break(brk),
    .o_uart_tx(tx[2]), .o_busy(busy[2]));

  task automatic update_fifo();
    for (int i = 0; i < 3; i++) begin
      empty_n[i] = (fq[i].size() > 0);
      fdata[i]   = (fq[i].size() > 0) ? fq[i][0] : 8'($urandom);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then apply pops after the edge.
  task automatic tick();
    logic [2:0] rd_now;
    @(negedge clk);
    rd_now = rd;
    if (cyc < LOGN) begin
      for (int i = 0; i < 3; i++) begin
        tx_log[i][cyc]   = tx[i];
        rd_log[i][cyc]   = rd[i];
        busy_log[i][cyc] = busy[i];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rd_now[i] && (fq[i].size() > 0)) void'(fq[i].pop_front());
    end
    update_fifo();
    cyc++;
  endtask

  function automatic void set_level(int inst, int from, int to, logic txv, logic busyv);
    for (int c = from; c <= to && c < LOGN; c++) begin
      exp_tx[inst][c]   = txv;
      exp_busy[inst][c] = busyv;
      exp_rd[inst][c]   = 1'b0;
    end
  endfunction

  // Reference frame: pop at t, then each frame bit lasts eff cycles from t+1.
  // Returns the cycle of the last stop bit (the next boundary).
  function automatic int add_frame(int inst, logic [7:0] b, int eff, int t);
    logic bits [0:11];
    int   nb;
    int   pc;
    bits[0] = 1'b0;
    nb = 1;
    pc = 0;
    for (int j = 0; j < DB[inst]; j++) begin
      bits[nb] = b[j];
      pc = pc + int'(b[j]);
      nb++;
    end
    if (PA[inst] == 2) begin
      bits[nb] = (pc % 2) == 1;
      nb++;
    end else if (PA[inst] == 1) begin
      bits[nb] = (pc % 2) == 0;
      nb++;
    end
    for (int s = 0; s < SB[inst]; s++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    if (t < LOGN) exp_rd[inst][t] = 1'b1;
    for (int k = 0; k < nb; k++) begin
      for (int e = 0; e < eff; e++) begin
        if (t + 1 + k * eff + e < LOGN) begin
          exp_tx[inst][t + 1 + k * eff + e]   = bits[k];
          exp_busy[inst][t + 1 + k * eff + e] = 1'b1;
        end
      end
    end
    return t + nb * eff;
  endfunction

  function automatic int count_diffs(int inst, int n, output int first);
    int d;
    d = 0;
    first = -1;
    for (int c = 0; c < n; c++) begin
      if (tx_log[inst][c] !== exp_tx[inst][c] || rd_log[inst][c] !== exp_rd[inst][c] ||
          busy_log[inst][c] !== exp_busy[inst][c]) begin
        if (first < 0) first = c;
        d++;
      end
    end
    return d;
  endfunction

  task automatic start_scenario();
    cyc = 0;
    brk = 1'b0;
    for (int i = 0; i < 3; i++) set_level(i, 0, LOGN - 1, 1'b1, 1'b0);
  endtask

  task automatic end_scenario();
    cts_n = 1'b1;
    brk   = 1'b0;
    for (int i = 0; i < 3; i++) fq[i].delete();
    update_fifo();
  endtask

  task automatic report_diff(string name, int inst, int d, int f);
    if (f >= 0) begin
      $display("FAIL %s dut%0d: %0d bad cycles, first at %0d tx=%b/%b rd=%b/%b busy=%b/%b (got/required), required 0",
               name, inst, d, f, tx_log[inst][f], exp_tx[inst][f], rd_log[inst][f], exp_rd[inst][f],
               busy_log[inst][f], exp_busy[inst][f]);
    end else begin
      $display("FAIL %s dut%0d: %0d bad cycles, required 0", name, inst, d);
    end
  endtask

  task automatic test_reset();
    cyc = 0;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[i][1] !== 1'b1) begin
        errors++; $display("FAIL reset_tx dut%0d: got %b, required 1", i, tx_log[i][1]);
      end
      checks++;
      if (busy_log[i][1] !== 1'b0) begin
        errors++; $display("FAIL reset_busy dut%0d: got %b, required 0", i, busy_log[i][1]);
      end
      checks++;
      if (rd_log[i][1] !== 1'b0) begin
        errors++; $display("FAIL reset_rd dut%0d: got %b, required 0", i, rd_log[i][1]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_char();
    int d, f, t, nrd, nbusy;
    start_scenario();
    setup = 24'd4;
    fq[0].push_back(8'h55);
    update_fifo();
    t = add_frame(0, 8'h55, 4, 0);
    cts_n = 1'b0;
    repeat (50) tick();
    d = count_diffs(0, 50, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("single_wave", 0, d, f); end
    nrd = 0; nbusy = 0;
    for (int c = 0; c < 50; c++) begin
      nrd   = nrd + int'(rd_log[0][c]);
      nbusy = nbusy + int'(busy_log[0][c]);
    end
    checks++;
    if (nrd !== 1) begin errors++; $display("FAIL single_rd_count: got %0d, required 1", nrd); end
    checks++;
    if (nbusy !== 40) begin errors++; $display("FAIL single_busy_len: got %0d, required 40", nbusy); end
    checks++;
    if (busy_log[0][t + 1] !== 1'b0) begin
      errors++; $display("FAIL single_busy_end: got %b, required 0", busy_log[0][t + 1]);
    end
    end_scenario();
  endtask

  task automatic test_back_to_back();
    int d, f, t, nrd;
    start_scenario();
    setup = 24'd4;
    fq[0].push_back(8'h00);
    fq[0].push_back(8'hFF);
    update_fifo();
    t = add_frame(0, 8'h00, 4, 0);
    t = add_frame(0, 8'hFF, 4, t);
    cts_n = 1'b0;
    repeat (90) tick();
    d = count_diffs(0, 90, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("b2b_wave", 0, d, f); end
    checks++;
    if (rd_log[0][40] !== 1'b1 || tx_log[0][41] !== 1'b0) begin
      errors++; $display("FAIL b2b_second_start: rd@40=%b tx@41=%b, required 1 and 0", rd_log[0][40], tx_log[0][41]);
    end
    nrd = 0;
    for (int c = 0; c < 90; c++) nrd = nrd + int'(rd_log[0][c]);
    checks++;
    if (nrd !== 2) begin errors++; $display("FAIL b2b_rd_count: got %0d, required 2", nrd); end
    end_scenario();
  endtask

  task automatic test_cts();
    int d, f, t;
    start_scenario();
    setup = 24'd4;
    fq[0].push_back(8'h3C);
    fq[0].push_back(8'h81);
    update_fifo();
    cts_n = 1'b1;
    t = add_frame(0, 8'h3C, 4, 20);
    for (int c = 0; c < 90; c++) begin
      if (c == 20) cts_n = 1'b0;
      if (c == 35) cts_n = 1'b1;
      tick();
    end
    d = count_diffs(0, 20, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("cts_hold", 0, d, f); end
    d = count_diffs(0, 90, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("cts_wave", 0, d, f); end
    checks++;
    if (fq[0].size() !== 1) begin errors++; $display("FAIL cts_left: got %0d, required 1", fq[0].size()); end
    end_scenario();
  endtask

  task automatic test_parity();
    int d, f, t;
    logic [7:0] b;
    start_scenario();
    setup = 24'd4;
    fq[1].push_back(8'h07);
    fq[2].push_back(8'h07);
    update_fifo();
    t = add_frame(1, 8'h07, 4, 0);
    t = add_frame(2, 8'h07, 4, 0);
    cts_n = 1'b0;
    repeat (60) tick();
    checks++;
    if (tx_log[1][37] !== 1'b1) begin errors++; $display("FAIL parity_even_bit: got %b, required 1", tx_log[1][37]); end
    checks++;
    if (tx_log[2][33] !== 1'b0) begin errors++; $display("FAIL parity_odd_bit: got %b, required 0", tx_log[2][33]); end
    for (int i = 1; i < 3; i++) begin
      d = count_diffs(i, 60, f);
      checks++;
      if (d !== 0) begin errors++; report_diff("parity_wave", i, d, f); end
    end
    end_scenario();
    // Zero setting: every bit is one cycle.
    start_scenario();
    setup = 24'd0;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        fq[i].push_back(b);
        t = add_frame(i, b, 1, t);
      end
    end
    update_fifo();
    cts_n = 1'b0;
    repeat (50) tick();
    for (int i = 0; i < 3; i++) begin
      d = count_diffs(i, 50, f);
      checks++;
      if (d !== 0) begin errors++; report_diff("setup0_wave", i, d, f); end
    end
    end_scenario();
  endtask

  task automatic test_break();
    int d, f, t;
    start_scenario();
    setup = 24'd4;
    fq[0].push_back(8'hA5);
    fq[0].push_back(8'h3C);
    update_fifo();
    t = add_frame(0, 8'hA5, 4, 0);
    set_level(0, t + 1, 60, 1'b0, 1'b1);
    set_level(0, 61, 64, 1'b1, 1'b1);
    t = add_frame(0, 8'h3C, 4, 64);
    cts_n = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (c == 18) brk = 1'b1;
      if (c == 60) brk = 1'b0;
      tick();
    end
    d = count_diffs(0, 120, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("break_wave", 0, d, f); end
    checks++;
    if (tx_log[0][50] !== 1'b0) begin errors++; $display("FAIL break_low: got %b, required 0", tx_log[0][50]); end
    checks++;
    if (rd_log[0][64] !== 1'b1) begin errors++; $display("FAIL break_resume_rd: got %b, required 1", rd_log[0][64]); end
    end_scenario();
  endtask

  task automatic test_reset_mid();
    int d, f, t;
    start_scenario();
    setup = 24'd4;
    fq[0].push_back(8'h5A);
    fq[0].push_back(8'hC3);
    update_fifo();
    t = add_frame(0, 8'h5A, 4, 0);
    set_level(0, 27, LOGN - 1, 1'b1, 1'b0);
    t = add_frame(0, 8'hC3, 4, 28);
    cts_n = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c == 26) rst = 1'b1;
      if (c == 28) rst = 1'b0;
      tick();
    end
    checks++;
    if (tx_log[0][27] !== 1'b1 || busy_log[0][27] !== 1'b0 || rd_log[0][27] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: tx=%b busy=%b rd=%b, required 1 0 0", tx_log[0][27], busy_log[0][27], rd_log[0][27]);
    end
    d = count_diffs(0, 80, f);
    checks++;
    if (d !== 0) begin errors++; report_diff("rst_mid_wave", 0, d, f); end
    checks++;
    if (fq[0].size() !== 0) begin errors++; $display("FAIL rst_mid_left: got %0d, required 0", fq[0].size()); end
    end_scenario();
  endtask

  task automatic test_random();
    int d, f, t, s, eff, n;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      start_scenario();
      s = $urandom_range(0, 5);
      eff = (s == 0) ? 1 : s;
      setup = BW'(s);
      for (int i = 0; i < 3; i++) begin
        n = $urandom_range(1, 3);
        t = 0;
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          fq[i].push_back(b);
          t = add_frame(i, b, eff, t);
        end
      end
      update_fifo();
      cts_n = 1'b0;
      repeat (200) tick();
      for (int i = 0; i < 3; i++) begin
        d = count_diffs(i, 200, f);
        checks++;
        if (d !== 0) begin errors++; report_diff("random_wave", i, d, f); end
      end
      end_scenario();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    cts_n  = 1'b1;
    brk    = 1'b0;
    setup  = 24'd4;
    update_fifo();
    @(posedge clk);
    #1;
    test_reset();
    test_single_char();
    test_back_to_back();
    test_cts();
    test_parity();
    test_break();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
